// File: rtl/servo_pwm_multi_if.sv
// Setpoint command channel for servo_pwm_multi: one angle per handshake,
// addressed to a single channel.
interface servo_pwm_multi_if #(
  parameter int N_CH    = 4,
  parameter int ANGLE_W = 8
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic               cmd_valid;
  logic               cmd_ready;
  logic [CH_W-1:0]    cmd_ch;
  logic [ANGLE_W-1:0] cmd_angle;

  modport master (output cmd_valid, cmd_ch, cmd_angle, input cmd_ready);
  modport slave  (input cmd_valid, cmd_ch, cmd_angle, output cmd_ready);
endinterface

// File: rtl/servo_pwm_multi.sv
// N-channel servo PWM: rate-limited slewing toward per-channel setpoints once
// per frame, with per-channel latched over-current shutdown.
module servo_pwm_multi #(
  parameter int N_CH       = 4,
  parameter int ANGLE_W    = 8,
  parameter int ANGLE_MAX  = 180,
  parameter int CENTER     = 90,
  parameter int PERIOD_CYC = 2000000,
  parameter int MIN_PULSE  = 100000,
  parameter int STEP_CYC   = 555,
  parameter int SLEW_STEP  = 5,
  parameter int CUR_W      = 12,
  parameter int CUR_LIMIT  = 3000,
  parameter int FAULT_CNT  = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  servo_pwm_multi_if.slave                cmd,
  input  logic [N_CH-1:0][CUR_W-1:0]      meas_current,
  input  logic [N_CH-1:0]                 fault_clr,
  output logic [N_CH-1:0]                 pwm_out,
  output logic [N_CH-1:0][ANGLE_W-1:0]    pos_out,
  output logic [N_CH-1:0]                 moving,
  output logic [N_CH-1:0]                 fault,
  output logic                            frame_start
);
  localparam int CNT_W = $clog2(PERIOD_CYC + 1);
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int OC_W  = $clog2(FAULT_CNT + 1);

  localparam logic [CNT_W-1:0]   LAST      = CNT_W'(PERIOD_CYC - 1);
  localparam logic [CNT_W-1:0]   PULSE_RST = CNT_W'(MIN_PULSE + CENTER * STEP_CYC);
  localparam logic [ANGLE_W-1:0] CENTER_A  = ANGLE_W'(CENTER);
  localparam logic [ANGLE_W-1:0] AMAX_A    = ANGLE_W'(ANGLE_MAX);
  localparam logic [ANGLE_W-1:0] SLEW_A    = ANGLE_W'(SLEW_STEP);
  localparam logic [CUR_W-1:0]   LIMIT_C   = CUR_W'(CUR_LIMIT);
  localparam logic [OC_W-1:0]    OC_MAX    = OC_W'(FAULT_CNT);

  // The widest pulse must leave some low time in every frame.
  if (MIN_PULSE + ANGLE_MAX * STEP_CYC >= PERIOD_CYC) begin : g_fullscale_chk
    $error("servo_pwm_multi: full-scale pulse does not fit in PERIOD_CYC");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_MOVING, ST_FAULT} state_t;

  logic [CNT_W-1:0]   cnt;
  logic               boundary;
  logic               hs;
  logic [ANGLE_W-1:0] angle_clamp;

  assign boundary    = (cnt == LAST);
  assign hs          = cmd.cmd_valid && cmd.cmd_ready;
  assign angle_clamp = (cmd.cmd_angle > AMAX_A) ? AMAX_A : cmd.cmd_angle;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt           <= '0;
      frame_start   <= 1'b0;
      cmd.cmd_ready <= 1'b0;
    end else begin
      cnt           <= boundary ? '0 : cnt + 1'b1;
      frame_start   <= boundary;
      cmd.cmd_ready <= 1'b1;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t             st;
    logic [ANGLE_W-1:0] pos, tgt, tgt_nxt, pos_nxt, pos_upd;
    logic [CNT_W-1:0]   pulse_q, pulse_nxt;
    logic [OC_W-1:0]    oc_cnt, oc_nxt;
    logic               set_tgt, latch, fault_q, pwm_q;

    // Out-of-range channel indices simply match no lane.
    assign set_tgt = hs && (cmd.cmd_ch == CH_W'(i));

    always_comb begin
      pos_nxt = pos;
      if (!fault_q) begin
        if (tgt > pos)
          pos_nxt = (tgt - pos > SLEW_A) ? pos + SLEW_A : tgt;
        else if (tgt < pos)
          pos_nxt = (pos - tgt > SLEW_A) ? pos - SLEW_A : tgt;
      end
      pos_upd   = boundary ? pos_nxt : pos;
      pulse_nxt = CNT_W'(MIN_PULSE) + CNT_W'(pos_nxt) * CNT_W'(STEP_CYC);
      oc_nxt    = '0;
      if (meas_current[i] > LIMIT_C)
        oc_nxt = (oc_cnt == OC_MAX) ? oc_cnt : oc_cnt + 1'b1;
      latch   = boundary && (oc_nxt == OC_MAX);
      // A new target lands after this cycle's step, so a boundary-cycle
      // command is first acted on at the following boundary.
      tgt_nxt = set_tgt ? angle_clamp : tgt;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        st      <= ST_IDLE;
        pos     <= CENTER_A;
        tgt     <= CENTER_A;
        pulse_q <= PULSE_RST;
        oc_cnt  <= '0;
        fault_q <= 1'b0;
        pwm_q   <= 1'b0;
      end else begin
        pwm_q <= (cnt < pulse_q) && !fault_q;
        tgt   <= tgt_nxt;
        if (boundary) begin
          pos     <= pos_nxt;
          pulse_q <= pulse_nxt;
          oc_cnt  <= oc_nxt;
        end
        if (fault_clr[i]) begin
          fault_q <= 1'b0;
          oc_cnt  <= '0;
          st      <= (pos_upd == tgt_nxt) ? ST_IDLE : ST_MOVING;
        end else if (latch) begin
          fault_q <= 1'b1;
          st      <= ST_FAULT;
        end else if (st != ST_FAULT) begin
          st      <= (pos_upd == tgt_nxt) ? ST_IDLE : ST_MOVING;
        end
      end
    end

    assign pos_out[i] = pos;
    assign moving[i]  = (pos != tgt);
    assign fault[i]   = fault_q;
    assign pwm_out[i] = pwm_q;
  end
endmodule

// File: tb/tb_servo_pwm_multi.sv
// Frame-level directed bench for servo_pwm_multi: each table row drives one
// 400-cycle frame and checks measured high times plus post-boundary state.
module tb_servo_pwm_multi;
  localparam int N_CH = 4;
  localparam int PER  = 400;
  localparam int NO   = -1;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [N_CH-1:0][11:0]  meas_current;
  logic [N_CH-1:0]        fault_clr;
  logic [N_CH-1:0]        pwm_out;
  logic [N_CH-1:0][7:0]   pos_out;
  logic [N_CH-1:0]        moving;
  logic [N_CH-1:0]        fault;
  logic                   frame_start;

  always #5 clk = ~clk;

  servo_pwm_multi_if #(.N_CH(N_CH), .ANGLE_W(8)) cif ();

  servo_pwm_multi #(
    .N_CH(N_CH), .PERIOD_CYC(PER), .MIN_PULSE(20), .STEP_CYC(1),
    .SLEW_STEP(30), .CUR_LIMIT(1000), .FAULT_CNT(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cif), .meas_current(meas_current),
    .fault_clr(fault_clr), .pwm_out(pwm_out), .pos_out(pos_out),
    .moving(moving), .fault(fault), .frame_start(frame_start)
  );

  typedef struct {
    int ech, eang;          // command in the first cycle of the frame
    int lch, lang;          // command in the boundary cycle
    int clre, clrl;         // fault_clr in first / boundary cycle
    int cur3;               // ch3 current for the whole frame
    logic [3:0][15:0] hi;   // expected high cycles during this frame
    logic [3:0][7:0]  pos;  // expected pos after the boundary
    int mov, flt;
  } vec_t;

  vec_t tbl[$];
  int n_chk = 0;
  int n_err = 0;

  function automatic vec_t mk(int ech, int eang, int lch, int lang, int clre,
                              int clrl, int cur3, int h0, int h1, int h2, int h3,
                              int p0, int p1, int p2, int p3, int mov, int flt);
    vec_t v;
    v.ech = ech; v.eang = eang; v.lch = lch; v.lang = lang;
    v.clre = clre; v.clrl = clrl; v.cur3 = cur3;
    v.hi[0] = 16'(h0); v.hi[1] = 16'(h1); v.hi[2] = 16'(h2); v.hi[3] = 16'(h3);
    v.pos[0] = 8'(p0); v.pos[1] = 8'(p1); v.pos[2] = 8'(p2); v.pos[3] = 8'(p3);
    v.mov = mov; v.flt = flt;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Entered and left in a cycle where cnt==0 (frame_start high).
  task automatic run_frame(input vec_t v, input int idx);
    int hi[N_CH];
    for (int c = 0; c < N_CH; c++) hi[c] = 0;
    meas_current    = '0;
    meas_current[3] = 12'(v.cur3);
    fault_clr       = 4'(v.clre);
    if (v.ech >= 0) begin
      cif.cmd_valid = 1'b1; cif.cmd_ch = 2'(v.ech); cif.cmd_angle = 8'(v.eang);
    end
    for (int i = 0; i < PER; i++) begin
      if (i == PER - 1) begin
        fault_clr = 4'(v.clrl);
        if (v.lch >= 0) begin
          cif.cmd_valid = 1'b1; cif.cmd_ch = 2'(v.lch); cif.cmd_angle = 8'(v.lang);
        end
      end
      tick();
      if (i == 0) begin
        cif.cmd_valid = 1'b0;
        fault_clr     = '0;
      end
      for (int c = 0; c < N_CH; c++) hi[c] += int'(pwm_out[c]);
    end
    cif.cmd_valid = 1'b0;
    fault_clr     = '0;
    for (int c = 0; c < N_CH; c++) begin
      chk($sformatf("v%0d_hi%0d", idx, c), hi[c], int'(v.hi[c]));
      chk($sformatf("v%0d_pos%0d", idx, c), int'(pos_out[c]), int'(v.pos[c]));
    end
    chk($sformatf("v%0d_moving", idx), int'(moving), v.mov);
    chk($sformatf("v%0d_fault", idx), int'(fault), v.flt);
    chk($sformatf("v%0d_frame_start", idx), int'(frame_start), 1);
  endtask

  // Reset, check the reset state, release and measure time to first frame_start.
  task automatic do_reset(input string tag);
    int n;
    rst_n = 1'b0; cif.cmd_valid = 1'b0; fault_clr = '0; meas_current = '0;
    tick();
    for (int c = 0; c < N_CH; c++)
      chk($sformatf("%s_rst_pos%0d", tag, c), int'(pos_out[c]), 90);
    chk({tag, "_rst_pwm"}, int'(pwm_out), 0);
    chk({tag, "_rst_moving"}, int'(moving), 0);
    chk({tag, "_rst_fault"}, int'(fault), 0);
    chk({tag, "_rst_frame_start"}, int'(frame_start), 0);
    chk({tag, "_rst_ready"}, int'(cif.cmd_ready), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) chk({tag, "_ready_after_rel"}, int'(cif.cmd_ready), 1);
    end while (!frame_start && n < 1000);
    chk({tag, "_first_frame_len"}, n, PER);
  endtask

  initial begin
    cif.cmd_valid = 1'b0; cif.cmd_ch = '0; cif.cmd_angle = '0;
    fault_clr = '0; meas_current = '0;

    //              ech  eang lch lang clre clrl cur3  hi0 hi1 hi2 hi3  p0  p1  p2  p3  mov      flt
    tbl.push_back(mk(NO, 0,   NO, 0,   0,   0,   0,    110,110,110,110, 90, 90, 90, 90, 0,       0));
    tbl.push_back(mk(1,  180, NO, 0,   0,   0,   0,    110,110,110,110, 90,120, 90, 90, 4'b0010, 0));
    tbl.push_back(mk(NO, 0,   NO, 0,   0,   0,   0,    110,140,110,110, 90,150, 90, 90, 4'b0010, 0));
    tbl.push_back(mk(NO, 0,   NO, 0,   0,   0,   0,    110,170,110,110, 90,180, 90, 90, 0,       0));
    tbl.push_back(mk(NO, 0,   NO, 0,   0,   0,   0,    110,200,110,110, 90,180, 90, 90, 0,       0));
    // clamp to 180, then a boundary-cycle reversal that must not affect this step
    tbl.push_back(mk(2,  250, 2,  0,   0,   0,   0,    110,200,110,110, 90,180,120, 90, 4'b0100, 0));
    tbl.push_back(mk(NO, 0,   NO, 0,   0,   0,   0,    110,200,140,110, 90,180, 90, 90, 4'b0100, 0));
    tbl.push_back(mk(NO, 0,   NO, 0,   0,   0,   0,    110,200,110,110, 90,180, 60, 90, 4'b0100, 0));
    tbl.push_back(mk(NO, 0,   NO, 0,   0,   0,   0,    110,200, 80,110, 90,180, 30, 90, 4'b0100, 0));
    tbl.push_back(mk(NO, 0,   NO, 0,   0,   0,   0,    110,200, 50,110, 90,180,  0, 90, 0,       0));
    // partial step (10 < slew) and over-current sequence 2 over / 1 at limit
    tbl.push_back(mk(0,  100, NO, 0,   0,   0,   1001, 110,200, 20,110,100,180,  0, 90, 0,       0));
    tbl.push_back(mk(NO, 0,   NO, 0,   0,   0,   1001, 120,200, 20,110,100,180,  0, 90, 0,       0));
    tbl.push_back(mk(NO, 0,   NO, 0,   0,   0,   1000, 120,200, 20,110,100,180,  0, 90, 0,       0));
    tbl.push_back(mk(NO, 0,   NO, 0,   0,   0,   1001, 120,200, 20,110,100,180,  0, 90, 0,       0));
    tbl.push_back(mk(NO, 0,   NO, 0,   0,   0,   1001, 120,200, 20,110,100,180,  0, 90, 0,       0));
    tbl.push_back(mk(NO, 0,   NO, 0,   0,   0,   1001, 120,200, 20,110,100,180,  0, 90, 0,       4'b1000));
    // faulted: target moves, position holds, output dark
    tbl.push_back(mk(3,  0,   NO, 0,   0,   0,   0,    120,200, 20,  0,100,180,  0, 90, 4'b1000, 4'b1000));
    // clear in cycle cnt=0: that cycle's pwm was already computed with fault set
    tbl.push_back(mk(NO, 0,   NO, 0,   8,   0,   0,    120,200, 20,109,100,180,  0, 60, 4'b1000, 0));
    tbl.push_back(mk(NO, 0,   NO, 0,   0,   0,   1001, 120,200, 20, 80,100,180,  0, 30, 4'b1000, 0));
    tbl.push_back(mk(NO, 0,   NO, 0,   0,   0,   1001, 120,200, 20, 50,100,180,  0,  0, 0,       0));
    tbl.push_back(mk(NO, 0,   NO, 0,   0,   0,   0,    120,200, 20, 20,100,180,  0,  0, 0,       0));
    tbl.push_back(mk(NO, 0,   NO, 0,   0,   0,   1001, 120,200, 20, 20,100,180,  0,  0, 0,       0));
    tbl.push_back(mk(NO, 0,   NO, 0,   0,   0,   1001, 120,200, 20, 20,100,180,  0,  0, 0,       0));
    // clear in the latch cycle wins and zeroes the count
    tbl.push_back(mk(NO, 0,   NO, 0,   0,   8,   1001, 120,200, 20, 20,100,180,  0,  0, 0,       0));
    tbl.push_back(mk(NO, 0,   NO, 0,   0,   0,   1001, 120,200, 20, 20,100,180,  0,  0, 0,       0));
    tbl.push_back(mk(NO, 0,   NO, 0,   0,   0,   1001, 120,200, 20, 20,100,180,  0,  0, 0,       0));
    tbl.push_back(mk(NO, 0,   NO, 0,   0,   0,   1001, 120,200, 20, 20,100,180,  0,  0, 0,       4'b1000));
    tbl.push_back(mk(1,  0,   NO, 0,   0,   0,   0,    120,200, 20,  0,100,150,  0,  0, 4'b0010, 4'b1000));

    do_reset("init");
    foreach (tbl[i]) run_frame(tbl[i], i);

    // Reset in the middle of ch1's descent.
    repeat (200) tick();
    chk("pre_rst_pos1", int'(pos_out[1]), 150);
    do_reset("mid");
    for (int c = 0; c < N_CH; c++)
      chk($sformatf("post_rst_pos%0d", c), int'(pos_out[c]), 90);
    chk("post_rst_moving", int'(moving), 0);
    run_frame(mk(NO, 0, NO, 0, 0, 0, 0, 110, 110, 110, 110, 90, 90, 90, 90, 0, 0), 99);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/servo_pwm_multi.md
Name: servo_pwm_multi

Overview:
N-channel servo PWM generator; parametrised successor to the single-channel servo top. Accepts per-channel angle setpoints over a valid/ready command port, slews each channel toward its target at a bounded rate per PWM frame, and emits one pulse-width-modulated output per channel. Monitors per-channel current each frame and latches an over-current fault that forces the channel's PWM low until cleared.

Parameters:
N_CH, 4, number of servo channels
ANGLE_W, 8, angle field width (degrees, unsigned)
ANGLE_MAX, 180, max legal angle; larger commands clamp to this
CENTER, 90, reset position and target of every channel
PERIOD_CYC, 2000000, PWM frame length in clk cycles (20 ms @ 100 MHz)
MIN_PULSE, 100000, high time in cycles at angle 0
STEP_CYC, 555, added high-time cycles per degree
SLEW_STEP, 5, max degrees a channel moves per frame
CUR_W, 12, current sample width (unsigned)
CUR_LIMIT, 3000, over-current threshold (strictly greater trips)
FAULT_CNT, 3, consecutive over-current frames needed to latch fault

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
cmd_valid  in  1  setpoint command valid
cmd_ready  out  1  setpoint command ready
cmd_ch  in  $clog2(N_CH)  target channel index
cmd_angle  in  ANGLE_W  requested angle, degrees
meas_current  in  N_CH*CUR_W  packed per-channel current samples, ch0 in LSBs
fault_clr  in  N_CH  per-channel fault clear, one-cycle pulse
pwm_out  out  N_CH  per-channel PWM
pos_out  out  N_CH*ANGLE_W  packed current commanded position per channel
moving  out  N_CH  1 while pos != target
fault  out  N_CH  latched over-current fault
frame_start  out  1  one-cycle pulse in the cycle cnt wraps to 0

Behaviour:
- Reset (rst_n=0 at clk edge): cnt=0, all pos=target=CENTER, pulse_q=MIN_PULSE+CENTER*STEP_CYC, oc_cnt=0, fault=0, pwm_out=0, frame_start=0, cmd_ready=0. Reset mid-frame aborts the frame; the next frame starts at cnt=0 one cycle after release.
- cmd_ready=1 in every cycle after reset release (registered). Handshake = cmd_valid & cmd_ready. On handshake: target[cmd_ch] <= min(cmd_angle, ANGLE_MAX). cmd_ch >= N_CH: accepted, no effect. Commands to a faulted channel update the target only.
- Frame counter: cnt counts 0..PERIOD_CYC-1 and wraps. Boundary = cycle where cnt==PERIOD_CYC-1; frame_start asserts in the following cycle (cnt==0).
- At each boundary, per channel, in parallel:
  - Non-fault: pos moves toward target by min(|target-pos|, SLEW_STEP); no overshoot.
  - Faulted: pos held.
  - pulse_q <= MIN_PULSE + pos_next*STEP_CYC (full-width multiply, no truncation).
  - If meas_current[ch] > CUR_LIMIT, oc_cnt++ (saturating), else oc_cnt=0. Fault latches when oc_cnt reaches FAULT_CNT.
- Same-cycle handshake and boundary: the step uses the pre-update target; the new target takes effect at the next boundary.
- pwm_out[ch] registered: pwm_out <= (cnt < pulse_q[ch]) & ~fault[ch]. One cycle latency from cnt.
- moving[ch] = (pos != target), combinational from registers. pos_out mirrors pos.
- Per-channel state: IDLE (pos==target) -> MOVING on target change; MOVING -> IDLE on reaching target; any -> FAULT on latch; FAULT -> IDLE/MOVING on fault_clr. fault_clr also zeroes oc_cnt. fault_clr in the latch cycle: clear wins.
- Full-scale check: MIN_PULSE + ANGLE_MAX*STEP_CYC < PERIOD_CYC is an elaboration-time assertion.

Test Plan:
Bench config: PERIOD_CYC=400, MIN_PULSE=20, STEP_CYC=1, SLEW_STEP=30, CUR_LIMIT=1000, FAULT_CNT=3, N_CH=4.
- Reset released, no commands -> every pwm_out high for exactly 110 cycles per 400-cycle frame; pos_out=90 on all channels; moving=0, fault=0.
- cmd ch1 angle=180 -> pos1 steps 120,150,180 on successive boundaries; moving[1]=0 after the third boundary; high time 200 cycles from then on; other channels unchanged.
- cmd ch2 angle=250 -> clamped target 180; cmd ch2 angle=0 in the boundary cycle -> that boundary steps toward 180 (pos=120), then descends by 30 per frame to 0 (high time 20).
- meas_current ch3=1001 for 3 frames -> fault[3]=1 at the third boundary, pwm_out[3]=0; 2 frames over then 1 under -> no fault.
- Faulted ch3 with cmd angle=0, then fault_clr[3] -> pos held while faulted, then slews from 90 to 0 in 3 frames; oc_cnt restarts from 0.
- Assert rst_n=0 mid-move on ch1 (pos=150) -> next cycle all pos=90, pwm_out=0; frame restarts at cnt=0 after release.
